// File: rtl/watch_pkg.sv
// Shared time-field limits and set-mode field select encodings for the watch path.
package watch_pkg;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    typedef enum logic [1:0] {
        SEL_SEC  = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_HOUR = 2'd2,
        SEL_NONE = 2'd3
    } sel_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter 0..MAX with synchronous clear and a combinational wrap strobe.
module mod_counter #(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    assign wrap = en & (q == MAX);

    // Count on enable, wrapping at MAX; clear has priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == MAX) ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/watch_timekeeper.sv
// 24-hour timekeeper: 1 Hz prescaler plus cascaded sec/min/hour fields with manual set.
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       sec_tick
);

    localparam int unsigned    PW     = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  PS_MAX = PW'(CLK_HZ - 1);

    logic          cnt_en;
    logic [PW-1:0] ps_q;
    logic          tick;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_wrap_unused;
    logic          sec_en;
    logic          min_en;
    logic          hour_en;

    assign cnt_en = run & ~set_en;

    // Carries only ripple while counting, so set-mode wraps of one field never touch the next.
    assign sec_en  = (cnt_en & tick)     | (set_en & inc & (set_sel == SEL_SEC));
    assign min_en  = (cnt_en & sec_wrap) | (set_en & inc & (set_sel == SEL_MIN));
    assign hour_en = (cnt_en & min_wrap) | (set_en & inc & (set_sel == SEL_HOUR));

    mod_counter #(.WIDTH(PW), .MAX(PS_MAX)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (set_en),
        .en   (cnt_en),
        .q    (ps_q),
        .wrap (tick)
    );

    mod_counter #(.WIDTH(8), .MAX(SEC_MAX)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (sec_en),
        .q    (sec),
        .wrap (sec_wrap)
    );

    mod_counter #(.WIDTH(8), .MAX(MIN_MAX)) u_min (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (min_en),
        .q    (min),
        .wrap (min_wrap)
    );

    mod_counter #(.WIDTH(8), .MAX(HOUR_MAX)) u_hour (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (hour_en),
        .q    (hour),
        .wrap (hour_wrap_unused)
    );

    // Flag the cycle in which an automatically advanced seconds value first appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
        end
    end

endmodule

// File: tb/tb_watch_timekeeper.sv
// Self-checking bench for watch_timekeeper with CLK_HZ = 4.
module tb_watch_timekeeper;

    localparam int unsigned CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       set_en = 1'b0;
    logic [1:0] set_sel = 2'd0;
    logic       inc = 1'b0;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       sec_tick;

    watch_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .set_en   (set_en),
        .set_sel  (set_sel),
        .inc      (inc),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: seconds-of-day plus a phase counter within the current second.
    int m_t   = 0;
    int m_ps  = 0;
    int m_tick = 0;

    typedef struct {
        logic       r;
        logic       s;
        logic [1:0] sel;
        logic       i;
        int         e_sec;
        int         e_min;
        int         e_hour;
        int         e_tick;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_t = 0;
        m_ps = 0;
        m_tick = 0;
    endfunction

    function automatic void model_step(input logic r, input logic s, input logic [1:0] sel, input logic i);
        int h, mi, se;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        se = m_t % 60;
        m_tick = 0;
        if (s) begin
            m_ps = 0;
            if (i) begin
                case (sel)
                    2'd0: se = (se + 1) % 60;
                    2'd1: mi = (mi + 1) % 60;
                    2'd2: h  = (h + 1) % 24;
                    default: ;
                endcase
            end
            m_t = h * 3600 + mi * 60 + se;
        end else if (r) begin
            if (m_ps == int'(CLK_HZ) - 1) begin
                m_ps = 0;
                m_t = (m_t + 1) % 86400;
                m_tick = 1;
            end else begin
                m_ps++;
            end
        end
    endfunction

    task automatic chk_model(input string name);
        chk({name, ".sec"},  {24'd0, sec},  m_t % 60);
        chk({name, ".min"},  {24'd0, min},  (m_t / 60) % 60);
        chk({name, ".hour"}, {24'd0, hour}, m_t / 3600);
        chk({name, ".tick"}, {31'd0, sec_tick}, m_tick);
    endtask

    // Called just after a falling edge: apply inputs, take the rising edge, return at the next falling edge.
    task automatic cycle(input logic r, input logic s, input logic [1:0] sel, input logic i);
        run = r;
        set_en = s;
        set_sel = sel;
        inc = i;
        @(posedge clk);
        model_step(r, s, sel, i);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run = 1'b0;
        set_en = 1'b0;
        inc = 1'b0;
        set_sel = 2'd0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk_model("reset");
        rst = 1'b1;
    endtask

    task automatic set_field(input logic [1:0] sel, input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, 1'b1, sel, 1'b1);
        end
    endtask

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 1, 0, 0, 1};
        vecs[4]  = '{1, 0, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 1, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 2, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 2, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 2, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 2, 0, 0, 0};
        vecs[11] = '{1, 0, 0, 0, 2, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 2, 0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 3, 0, 0, 1};
        vecs[14] = '{1, 0, 0, 0, 3, 0, 0, 0};
        vecs[15] = '{1, 0, 0, 0, 3, 0, 0, 0};
        vecs[16] = '{1, 1, 1, 1, 3, 1, 0, 0};
        vecs[17] = '{1, 1, 3, 1, 3, 1, 0, 0};
        vecs[18] = '{1, 1, 2, 1, 3, 1, 1, 0};
        vecs[19] = '{1, 1, 0, 1, 4, 1, 1, 0};
        vecs[20] = '{1, 1, 0, 0, 4, 1, 1, 0};
        vecs[21] = '{1, 0, 0, 1, 4, 1, 1, 0};
        vecs[22] = '{1, 0, 0, 1, 4, 1, 1, 0};
        vecs[23] = '{1, 0, 0, 1, 4, 1, 1, 0};
        vecs[24] = '{1, 0, 0, 1, 5, 1, 1, 1};

        @(negedge clk);
        do_reset();

        // Table: first tick, hold, set mode, ignored inc.
        for (int v = 0; v < 25; v++) begin
            cycle(vecs[v].r, vecs[v].s, vecs[v].sel, vecs[v].i);
            chk($sformatf("vec%0d.sec", v),  {24'd0, sec},  vecs[v].e_sec);
            chk($sformatf("vec%0d.min", v),  {24'd0, min},  vecs[v].e_min);
            chk($sformatf("vec%0d.hour", v), {24'd0, hour}, vecs[v].e_hour);
            chk($sformatf("vec%0d.tick", v), {31'd0, sec_tick}, vecs[v].e_tick);
        end

        // Full rollover from 23:59:59 in one edge.
        do_reset();
        set_field(2'd2, 23);
        set_field(2'd1, 59);
        set_field(2'd0, 59);
        chk_model("preset");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 2'd0, 1'b0);
            chk_model("roll_wait");
        end
        cycle(1'b1, 1'b0, 2'd0, 1'b0);
        chk("roll.hms", {8'd0, hour, min, sec}, 32'd0);
        chk("roll.tick", {31'd0, sec_tick}, 32'd1);
        chk_model("roll");

        // min 59 with sec not wrapping: no hour carry.
        set_field(2'd1, 59);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 2'd0, 1'b0);
        chk("m59.min", {24'd0, min}, 32'd59);
        chk("m59.hour", {24'd0, hour}, 32'd0);
        chk_model("m59");

        // 25 hour increments in set mode from hour 0 wrap to 1.
        do_reset();
        set_field(2'd2, 25);
        chk("h25.hour", {24'd0, hour}, 32'd1);
        chk("h25.minsec", {16'd0, min, sec}, 32'd0);
        chk("h25.tick", {31'd0, sec_tick}, 32'd0);
        set_field(2'd3, 5);
        chk_model("selnone");

        // set_en asserted in the tick cycle wins; next tick a full period after it drops.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 2'd0, 1'b0);
        chk_model("pretick");
        cycle(1'b1, 1'b1, 2'd0, 1'b0);
        chk("prio.sec", {24'd0, sec}, 32'd0);
        chk("prio.tick", {31'd0, sec_tick}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 2'd0, 1'b0);
            chk("prio_wait.sec", {24'd0, sec}, 32'd0);
        end
        cycle(1'b1, 1'b0, 2'd0, 1'b0);
        chk("prio_next.sec", {24'd0, sec}, 32'd1);
        chk("prio_next.tick", {31'd0, sec_tick}, 32'd1);
        chk_model("prio");

        // Asynchronous reset between edges at 12:34:56.
        do_reset();
        set_field(2'd2, 12);
        set_field(2'd1, 34);
        set_field(2'd0, 56);
        chk_model("pre_async");
        cycle(1'b1, 1'b0, 2'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async.hms", {8'd0, hour, min, sec}, 32'd0);
        chk("async.tick", {31'd0, sec_tick}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, 2'd0, 1'b0);
            chk_model("async_resume");
        end

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
